// File: rtl/board_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_controller: Connect Four move acceptance, bottom-up column scan and
// token placement on a 6x7 board. Rev 1.0
// ---------------------------------------------------------------------------
module board_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic       pve,
  input  logic       new_game,
  input  logic [6:0] human_move,
  input  logic       human_confirm,
  input  logic [6:0] bot_move,
  input  logic       bot_confirm,
  input  logic       game_won,
  output logic [1:0] tokens [6][7],
  output logic       bot_turn,
  output logic [1:0] current_player,
  output logic [5:0] move_count,
  output logic       illegal,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_PLACE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] board_q [6][7];
  logic [1:0] board_d [6][7];
  logic [1:0] player_q, player_d;
  logic [5:0] count_q, count_d;
  logic       illegal_q, illegal_d;
  logic       hc_prev_q, hc_prev_d;
  logic [2:0] col_q, col_d;
  logic [2:0] row_q, row_d;

  logic [6:0] sel_move;
  logic       sel_confirm;
  logic [2:0] sel_col;

  assign bot_turn       = pve & (player_q == 2'b10) & (state_q != S_DONE);
  assign game_over      = (state_q == S_DONE);
  assign current_player = player_q;
  assign move_count     = count_q;
  assign illegal        = illegal_q;
  assign tokens         = board_q;

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    player_d  = player_q;
    count_d   = count_q;
    col_d     = col_q;
    row_d     = row_q;
    illegal_d = 1'b0;
    hc_prev_d = human_confirm;

    // Only the source whose turn it is can confirm; the bot's idle code is inert.
    sel_move    = bot_turn ? bot_move : human_move;
    sel_confirm = bot_turn ? (bot_confirm && (bot_move != 7'd9))
                           : (human_confirm && !hc_prev_q);
    sel_col = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (sel_move[i]) sel_col = 3'(i);
    end

    case (state_q)
      S_IDLE: begin
        if (game_won) begin
          state_d = S_DONE;
        end else if (sel_confirm) begin
          if (!$onehot(sel_move) || (board_q[0][sel_col] != 2'b00)) begin
            illegal_d = 1'b1;
          end else begin
            col_d   = sel_col;
            row_d   = 3'd5;
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        // row_q is held as the landing row once an empty cell is found
        if (board_q[row_q][col_q] == 2'b00) state_d = S_PLACE;
        else                                row_d   = row_q - 3'd1;
      end
      S_PLACE: begin
        board_d[row_q][col_q] = player_q;
        count_d  = count_q + 6'd1;
        player_d = ~player_q;
        state_d  = (count_q == 6'd41) ? S_DONE : S_IDLE;
      end
      default: ;
    endcase

    if (new_game) begin
      state_d   = S_IDLE;
      player_d  = 2'b01;
      count_d   = 6'd0;
      illegal_d = 1'b0;
      hc_prev_d = 1'b0;
      col_d     = 3'd0;
      row_d     = 3'd0;
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++)
          board_d[r][c] = 2'b00;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      player_q  <= 2'b01;
      count_q   <= 6'd0;
      illegal_q <= 1'b0;
      hc_prev_q <= 1'b0;
      col_q     <= 3'd0;
      row_q     <= 3'd0;
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++)
          board_q[r][c] <= 2'b00;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      player_q  <= player_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      hc_prev_q <= hc_prev_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

endmodule
`default_nettype wire
